// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed 32-bit multiply / divide unit.
// One operation in flight. Fixed latency of 33 cycles from the start edge to
// the registered result: 1 launch edge, 32 iteration edges (shift-add for
// MULT, restoring division for DIV), then one DONE edge that applies the sign
// fix and raises data_resultRDY for exactly one cycle.
// Handshake: the start pulses (ctrl_MULT / ctrl_DIV) are accepted only in IDLE.
// The caller must hold off while busy is high. Each accepted start produces
// exactly one data_resultRDY pulse unless reset aborts the operation.
module multdiv_iter (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        is_mult;
    logic        neg;       // result sign: operand signs differ
    logic        b_zero;    // divisor was zero
    logic [31:0] acc_hi;    // MULT: product high half / DIV: partial remainder
    logic [31:0] acc_lo;    // MULT: product low half + multiplier / DIV: quotient + dividend
    logic [31:0] opnd;      // MULT: multiplicand magnitude / DIV: divisor magnitude

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mult_sum;
    logic [32:0] div_sh;
    logic [32:0] div_sub;
    logic [63:0] prod_mag;
    logic [63:0] prod_s;
    logic [31:0] quo_s;

    assign dbg_state = state;

    // Operand magnitudes, one iteration step for each op, and the sign fix.
    // |0x80000000| comes out as unsigned 0x80000000, which is what we want.
    always_comb begin
        mag_a    = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
        mag_b    = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;
        mult_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
        div_sh   = {acc_hi, acc_lo[31]};
        div_sub  = div_sh - {1'b0, opnd};
        prod_mag = {acc_hi, acc_lo};
        prod_s   = neg ? (64'd0 - prod_mag) : prod_mag;
        quo_s    = neg ? (32'd0 - acc_lo) : acc_lo;
    end

    // Control FSM, datapath iteration and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= 5'd0;
            is_mult        <= 1'b0;
            neg            <= 1'b0;
            b_zero         <= 1'b0;
            acc_hi         <= 32'd0;
            acc_lo         <= 32'd0;
            opnd           <= 32'd0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl_MULT || ctrl_DIV) begin
                        // MULT wins when both starts arrive together
                        is_mult <= ctrl_MULT;
                        neg     <= data_operandA[31] ^ data_operandB[31];
                        b_zero  <= (data_operandB == 32'd0);
                        acc_hi  <= 32'd0;
                        acc_lo  <= ctrl_MULT ? mag_b : mag_a;
                        opnd    <= ctrl_MULT ? mag_a : mag_b;
                        cnt     <= 5'd0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (is_mult) begin
                        acc_hi <= mult_sum[32:1];
                        acc_lo <= {mult_sum[0], acc_lo[31:1]};
                    end else if (!div_sub[32]) begin
                        acc_hi <= div_sub[31:0];
                        acc_lo <= {acc_lo[30:0], 1'b1};
                    end else begin
                        acc_hi <= div_sh[31:0];
                        acc_lo <= {acc_lo[30:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (is_mult) begin
                        data_result    <= prod_s[31:0];
                        data_exception <= (prod_s[63:32] != {32{prod_s[31]}});
                    end else if (b_zero) begin
                        data_result    <= 32'd0;
                        data_exception <= 1'b1;
                    end else begin
                        data_result    <= quo_s;
                        // only INT_MIN / -1 yields a positive quotient >= 2^31
                        data_exception <= !neg && acc_lo[31];
                    end
                    data_resultRDY <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed testbench for multdiv_iter: reset, multiply and divide vectors,
// ignored starts while busy / in DONE, back-to-back launch, reset abort.
module tb_multdiv_iter;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks;
    int errors;

    multdiv_iter dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // drive one start pulse so that it is sampled at the next rising edge (edge 0)
    task automatic launch(input logic mult, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = mult;
        ctrl_DIV      = ~mult;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // wait up to limit edges for data_resultRDY; lat = edge index, 0 on timeout
    task automatic wait_rdy(input int limit, output int lat, output int busy_low);
        lat      = 0;
        busy_low = 0;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = k;
                return;
            end
            if (!busy) busy_low++;
        end
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 ||
            busy !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: result=%h exc=%b rdy=%b busy=%b state=%0d, want 0/0/0/0/0",
                     data_result, data_exception, data_resultRDY, busy, dbg_state);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_mult;
        logic [31:0] va [5] = '{32'd6, 32'hFFFFFFFD, 32'h00010000, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] vb [5] = '{32'd7, 32'd5,        32'h00010000, 32'd1,        32'd2};
        logic [31:0] er [5] = '{32'h2A, 32'hFFFFFFF1, 32'h0,       32'h80000000, 32'hFFFFFFFE};
        logic        ee [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat, busy_low;
        for (int i = 0; i < 5; i++) begin
            launch(1'b1, va[i], vb[i]);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL mult%0d_busy_start: busy=%b want 1", i, busy);
            end
            wait_rdy(40, lat, busy_low);
            checks++;
            if (lat != 33 || busy_low != 0) begin
                errors++;
                $display("FAIL mult%0d_latency: lat=%0d busy_low=%0d want 33/0", i, lat, busy_low);
            end
            checks++;
            if (data_result !== er[i] || data_exception !== ee[i] || busy !== 1'b0) begin
                errors++;
                $display("FAIL mult%0d_result: got %h exc=%b busy=%b want %h exc=%b busy=0",
                         i, data_result, data_exception, busy, er[i], ee[i]);
            end
            @(posedge clock);
            #1;
            checks++;
            if (data_resultRDY !== 1'b0 || data_result !== er[i]) begin
                errors++;
                $display("FAIL mult%0d_rdy_pulse: rdy=%b result=%h want 0 / %h",
                         i, data_resultRDY, data_result, er[i]);
            end
        end
    endtask

    task automatic test_div;
        logic [31:0] va [5] = '{32'hFFFFFFF9, 32'd100,     32'd5,  32'h80000000, 32'hFFFFFF9C};
        logic [31:0] vb [5] = '{32'd2,        32'hFFFFFFF6, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9};
        logic [31:0] er [5] = '{32'hFFFFFFFD, 32'hFFFFFFF6, 32'd0, 32'h80000000, 32'h0000000E};
        logic        ee [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat, busy_low;
        for (int i = 0; i < 5; i++) begin
            launch(1'b0, va[i], vb[i]);
            wait_rdy(40, lat, busy_low);
            checks++;
            if (lat != 33 || busy_low != 0) begin
                errors++;
                $display("FAIL div%0d_latency: lat=%0d busy_low=%0d want 33/0", i, lat, busy_low);
            end
            checks++;
            if (data_result !== er[i] || data_exception !== ee[i]) begin
                errors++;
                $display("FAIL div%0d_result: got %h exc=%b want %h exc=%b",
                         i, data_result, data_exception, er[i], ee[i]);
            end
            @(posedge clock);
            #1;
            checks++;
            if (data_resultRDY !== 1'b0) begin
                errors++;
                $display("FAIL div%0d_rdy_pulse: rdy=%b want 0", i, data_resultRDY);
            end
        end
    endtask

    task automatic test_ignore_busy;
        int lat, busy_low, extra;
        launch(1'b1, 32'd2, 32'd3);
        repeat (9) @(posedge clock);
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd5;
        @(posedge clock);   // edge 10
        #1;
        ctrl_DIV = 1'b0;
        wait_rdy(30, lat, busy_low);
        checks++;
        if (lat + 10 != 33 || data_result !== 32'd6 || data_exception !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy_result: edge=%0d result=%h exc=%b want 33 / 6 / 0",
                     lat + 10, data_result, data_exception);
        end
        extra = 0;
        for (int k = 34; k <= 70; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ignore_busy_second_pulse: pulses=%0d want 0", extra);
        end
    endtask

    task automatic test_ignore_done;
        int stray_rdy, stray_busy;
        launch(1'b1, 32'd4, 32'd5);
        repeat (32) @(posedge clock);
        #1;
        ctrl_DIV      = 1'b1;   // sampled at edge 33, the DONE edge
        data_operandA = 32'd9;
        data_operandB = 32'd3;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        checks++;
        if (data_resultRDY !== 1'b1 || data_result !== 32'd20) begin
            errors++;
            $display("FAIL done_edge_result: rdy=%b result=%h want 1 / 00000014",
                     data_resultRDY, data_result);
        end
        stray_rdy  = 0;
        stray_busy = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) stray_rdy++;
            if (busy) stray_busy++;
        end
        checks++;
        if (stray_rdy != 0 || stray_busy != 0) begin
            errors++;
            $display("FAIL done_edge_start_ignored: rdy=%0d busy=%0d want 0/0", stray_rdy, stray_busy);
        end
    endtask

    task automatic test_back_to_back;
        int lat, busy_low;
        launch(1'b1, 32'd3, 32'd3);
        wait_rdy(40, lat, busy_low);
        checks++;
        if (lat != 33 || data_result !== 32'd9) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d result=%h want 33 / 00000009", lat, data_result);
        end
        ctrl_MULT     = 1'b1;   // sampled at edge 34
        data_operandA = 32'd7;
        data_operandB = 32'd8;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        checks++;
        if (busy !== 1'b1 || data_resultRDY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b rdy=%b want 1/0", busy, data_resultRDY);
        end
        wait_rdy(40, lat, busy_low);
        checks++;
        if (lat != 33 || data_result !== 32'd56 || data_exception !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d result=%h exc=%b want 33 / 00000038 / 0",
                     lat, data_result, data_exception);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_abort;
        int lat, busy_low, stray;
        launch(1'b0, 32'd1000, 32'd3);
        repeat (15) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 ||
            busy !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL abort_clear: result=%h exc=%b rdy=%b busy=%b state=%0d want all 0",
                     data_result, data_exception, data_resultRDY, busy, dbg_state);
        end
        @(negedge clock);
        reset = 1'b1;
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL abort_no_rdy: pulses=%0d want 0", stray);
        end
        launch(1'b1, 32'd4, 32'd4);
        wait_rdy(40, lat, busy_low);
        checks++;
        if (lat != 33 || data_result !== 32'h10 || data_exception !== 1'b0) begin
            errors++;
            $display("FAIL abort_fresh_mult: lat=%0d result=%h exc=%b want 33 / 00000010 / 0",
                     lat, data_result, data_exception);
        end
    endtask

    // sequence and report
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_div();
        test_ignore_busy();
        test_ignore_done();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
